// File: rtl/fifo_tx.sv
// fifo_tx: APB-written byte FIFO that serializes bytes LSB-first on en_tx strobes.
// Ports: clk, reset_n (async, active low), en_tx bit strobe, APB slave
// (psel/penable/pwrite/pwdata/prdata/pready/pslverr), data_out serial bit,
// tx_busy (mid-byte), mem_state (FIFO non-empty).
// Optional macro FIFO_TX_PARITY_EN: appends an even-parity bit after each byte.
module fifo_tx #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_tx,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic       data_out,
    output logic       tx_busy,
    output logic       mem_state
);

    localparam int CW = ADDR_W + 1;
`ifdef FIFO_TX_PARITY_EN
    localparam logic [3:0] LAST = 4'd9;
`else
    localparam logic [3:0] LAST = 4'd8;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              dout_q, dout_d;
    logic              busy_q, busy_d;
    logic              mst_q;

    logic       full, empty, acc, wr_ok, pop, byte_done;
    logic [7:0] head;
    logic [4:0] cnt_sat;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign acc       = psel & penable;
    assign wr_ok     = acc & pwrite & ~full;
    assign head      = mem_q[rd_ptr_q];
    // Idle or last bit just sent: the next strobe may fetch a new byte.
    assign byte_done = (state_q == IDLE) || (bit_cnt_q == LAST);
    assign pop       = en_tx & ~empty & byte_done;

    // APB side: zero wait-state, status on read
    always_comb begin
        cnt_sat = 5'd31;
        if (int'(count_q) <= 31) cnt_sat = 5'(count_q);
    end

    assign pready  = acc;
    assign pslverr = acc & pwrite & full;
    assign prdata  = (acc & ~pwrite) ? {full, empty, busy_q, cnt_sat} : 8'h00;

    always_comb begin
        unique case ({wr_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= pwdata;
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            dout_q    <= 1'b0;
            busy_q    <= 1'b0;
            mst_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
            busy_q    <= busy_d;
            mst_q     <= (count_d != '0);
            if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (en_tx) begin
            unique case (state_q)
                IDLE:    if (!empty) state_d = SHIFT;
                SHIFT:   if (bit_cnt_q == LAST && empty) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Serializer outputs
    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        dout_d    = dout_q;
        busy_d    = busy_q;
        if (en_tx) begin
            if (pop) begin
                shreg_d   = head;
                dout_d    = head[0];
                bit_cnt_d = 4'd1;
                busy_d    = 1'b1;
            end else if (state_q == SHIFT && bit_cnt_q != LAST) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                dout_d    = shreg_q[bit_cnt_q[2:0]];
`ifdef FIFO_TX_PARITY_EN
                if (bit_cnt_q == 4'd8) dout_d = ^shreg_q;
`endif
            end else begin
                dout_d    = 1'b0;
                busy_d    = 1'b0;
                bit_cnt_d = 4'd0;
            end
        end
    end

    assign data_out  = dout_q;
    assign tx_busy   = busy_q;
    assign mem_state = mst_q;

endmodule

// File: tb/tb_fifo_tx.sv
// tb_fifo_tx: directed + random stimulus for fifo_tx against a queue-based model.
// Model: byte queue plus pending-bit queue per strobe.
module tb_fifo_tx;

    localparam int DEPTH = 16;
`ifdef FIFO_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en_tx = 1'b0;
    logic       psel = 1'b0;
    logic       penable = 1'b0;
    logic       pwrite = 1'b0;
    logic [7:0] pwdata = 8'h00;
    logic [7:0] prdata;
    logic       pready, pslverr, data_out, tx_busy, mem_state;

    always #5 clk = ~clk;

    fifo_tx #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .en_tx(en_tx),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .data_out(data_out),
        .tx_busy(tx_busy), .mem_state(mem_state)
    );

    int n_run = 0;
    int n_fail = 0;

    logic [7:0] mq[$];
    bit         pend[$];
    bit         m_dout = 1'b0;
    bit         m_busy = 1'b0;
    bit         cap[$];
    logic [7:0] o_prdata;
    logic       o_pslverr;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit en, input bit acc, input bit wr,
                              input logic [7:0] d);
        bit full;
        logic [7:0] b;
        full = (mq.size() >= DEPTH);
        if (en) begin
            if (pend.size() > 0) begin
                m_dout = pend.pop_front();
                m_busy = 1'b1;
            end else if (mq.size() > 0) begin
                b = mq.pop_front();
                for (int i = 0; i < 8; i++) pend.push_back(b[i]);
`ifdef FIFO_TX_PARITY_EN
                pend.push_back(^b);
`endif
                m_dout = pend.pop_front();
                m_busy = 1'b1;
            end else begin
                m_dout = 1'b0;
                m_busy = 1'b0;
            end
        end
        if (acc && wr && !full) mq.push_back(d);
    endtask

    task automatic step(input bit en, input bit sel, input bit ena,
                        input bit wr, input logic [7:0] d);
        bit acc, full, emp;
        logic [7:0] exp_rd;
        en_tx = en; psel = sel; penable = ena; pwrite = wr; pwdata = d;
        acc  = sel & ena;
        full = (mq.size() >= DEPTH);
        emp  = (mq.size() == 0);
        #3;
        exp_rd = 8'h00;
        if (acc && !wr) exp_rd = {full, emp, m_busy, 5'(mq.size())};
        chk("pready", 16'(pready), 16'(acc));
        chk("pslverr", 16'(pslverr), 16'(acc & wr & full));
        chk("prdata", 16'(prdata), 16'(exp_rd));
        o_prdata  = prdata;
        o_pslverr = pslverr;
        @(posedge clk);
        #1;
        model_edge(en, acc, wr, d);
        chk("data_out", 16'(data_out), 16'(m_dout));
        chk("tx_busy", 16'(tx_busy), 16'(m_busy));
        chk("mem_state", 16'(mem_state), 16'(mq.size() != 0));
        if (en) cap.push_back(data_out);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic apb_wr(input logic [7:0] d, input bit en_acc);
        step(1'b0, 1'b1, 1'b0, 1'b1, d);
        step(en_acc, 1'b1, 1'b1, 1'b1, d);
    endtask

    task automatic apb_rd();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en_tx = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        #1;
        chk("rst_data_out", 16'(data_out), 16'h0);
        chk("rst_tx_busy", 16'(tx_busy), 16'h0);
        chk("rst_mem_state", 16'(mem_state), 16'h0);
        chk("rst_pready", 16'(pready), 16'h0);
        chk("rst_pslverr", 16'(pslverr), 16'h0);
        chk("rst_prdata", 16'(prdata), 16'h0);
        mq.delete();
        pend.delete();
        m_dout = 1'b0;
        m_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [15:0] v;
        int r;

        do_reset();

        // 1: single byte 0xA5, strobe every 25 clk
        apb_wr(8'hA5, 1'b0);
        cap.delete();
        repeat (NB) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
            idle(24);
        end
        v = '0;
        for (int i = 0; i < 8; i++) v[i] = cap[i];
        chk("t1_byte", v, 16'h00A5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t1_idle_bit", 16'(data_out), 16'h0);
        chk("t1_idle_busy", 16'(tx_busy), 16'h0);

        // 2: back-to-back bytes
        apb_wr(8'h01, 1'b0);
        apb_wr(8'h80, 1'b0);
        cap.delete();
        repeat (2 * NB) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`ifndef FIFO_TX_PARITY_EN
        v = '0;
        for (int i = 0; i < 16; i++) v[i] = cap[i];
        chk("t2_stream", v, 16'h8001);
`endif
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // 3: fill to overflow with no strobes
        for (int i = 0; i < 17; i++) begin
            apb_wr(8'(i * 13 + 5), 1'b0);
            if (i < 16) chk("t3_wr_ok", 16'(o_pslverr), 16'h0);
            else        chk("t3_wr_drop", 16'(o_pslverr), 16'h1);
        end
        apb_rd();
        chk("t3_status", 16'(o_prdata), 16'h0090);

        // 4: write on full while a pop happens in the same cycle
        apb_wr(8'hEE, 1'b1);
        chk("t4_pslverr", 16'(o_pslverr), 16'h1);
        apb_rd();
        chk("t4_status", 16'(o_prdata), 16'h002F);

        // 5: reset mid-byte with queued bytes
        do_reset();
        apb_wr(8'hFF, 1'b0);
        apb_wr(8'hAA, 1'b0);
        apb_wr(8'h55, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("t5_mid_bit", 16'(data_out), 16'h1);
        do_reset();
        apb_rd();
        chk("t5_status", 16'(o_prdata), 16'h0040);

`ifdef FIFO_TX_PARITY_EN
        // 6: parity bit after 0x07
        apb_wr(8'h07, 1'b0);
        cap.delete();
        repeat (9) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        v = '0;
        for (int i = 0; i < 9; i++) v[i] = cap[i];
        chk("t6_parity", v, 16'h0107);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

        // Random traffic, then drain
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 3);
            step($urandom_range(0, 2) == 0,
                 r != 0, r >= 2, r == 2, 8'($urandom));
        end
        repeat (300) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        apb_rd();
        chk("drain_status", 16'(o_prdata), 16'h0040);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_tx.md
Name: fifo_tx

Overview:
Transmit-side byte FIFO for the Zigbee baseband datapath; it is the counterpart of the receive FIFO.
- Software writes bytes over an APB slave port into a circular buffer.
- The block serializes the bytes LSB-first on data_out, advancing one bit per en_tx strobe, for the spreader/modulator.
- An APB read returns a status byte.

Parameters:
DEPTH, 16, number of byte entries (power of 2, ≥2)
ADDR_W, 4, pointer width = log2(DEPTH)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en_tx  input  1  bit-rate strobe, one clk cycle high per bit period
psel  input  1  APB select
penable  input  1  APB enable (access phase)
pwrite  input  1  APB direction, 1 = write
pwdata  input  8  APB write data (byte to transmit)
prdata  output  8  APB read data (status)
pready  output  1  APB ready
pslverr  output  1  APB error
data_out  output  1  serial bit to modulator
tx_busy  output  1  serializer is mid-byte
mem_state  output  1  0 = FIFO empty, 1 = FIFO holds ≥1 byte

Behaviour:
- Reset (async, reset_n=0):
  - All outputs are 0: prdata, pready, pslverr, data_out, tx_busy, mem_state.
  - Pointers, count and bit counter are cleared; the state machine goes to IDLE.
  - Reset mid-byte drops the partial byte and all queued bytes.
- APB:
  - Zero wait-state. pready=1 only in an access cycle (psel & penable), otherwise 0. pready and pslverr are combinational from the access phase.
  - Write access (pwrite=1):
    - If count<DEPTH at the start of the cycle, pwdata is stored at the write pointer, the write pointer increments (wraps at DEPTH) and pslverr=0.
    - If full, the byte is dropped and pslverr=1.
  - Read access (pwrite=0): prdata = {full, empty, tx_busy, count[4:0]} with count saturating at 31. pslverr=0. prdata=0 outside read access.
- Count:
  - Write alone: +1. Pop alone: −1. Write and pop in the same cycle: count unchanged.
  - Full is evaluated before the pop, so a write on a full FIFO is rejected even if a pop occurs in that cycle.
  - mem_state = (count!=0), registered.
- Serializer FSM states: IDLE and SHIFT. Registers shreg[7:0] and bit_cnt[3:0]. All transitions happen only in cycles where en_tx=1; outside those cycles everything holds.
  - IDLE, en_tx=1, FIFO non-empty:
    - Pop the byte, load shreg.
    - data_out ← byte[0], bit_cnt ← 1, tx_busy ← 1, go to SHIFT.
  - IDLE, en_tx=1, FIFO empty: data_out stays 0.
  - SHIFT, en_tx=1, bit_cnt<8: data_out ← shreg[bit_cnt], bit_cnt++.
  - SHIFT, en_tx=1, bit_cnt==8 (byte complete):
    - If the FIFO is non-empty, pop the next byte and output its bit0 in the same strobe. Back-to-back bytes have no gap.
    - Otherwise data_out ← 0, tx_busy ← 0, go to IDLE.
- Latency: a byte written into an empty, idle FIFO appears on data_out at the first en_tx strobe after the APB access cycle.
- The read pointer wraps at DEPTH. Pointer equality is disambiguated by count.

Optional Feature:
FIFO_TX_PARITY_EN
- Defined: after the 8 data bits, one extra en_tx period outputs even parity (XOR of the byte). Byte complete means bit_cnt==9. tx_busy stays 1 through the parity bit.
- Undefined: 8 bits per byte, no parity; logic removed.

Test Plan:
1. Reset, then write 0xA5 with en_tx pulsing every 25 clk → data_out over 8 strobes = 1,0,1,0,0,1,0,1. tx_busy=1 during these 8 strobes. mem_state=0 after the pop. data_out returns to 0 at the 9th strobe.
2. Write 0x01, 0x80 back-to-back → data_out = 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 with no idle bit between bytes.
3. en_tx=0, write 17 bytes → writes 1–16 have pslverr=0. Write 17 has pslverr=1 and is dropped. A read returns 0x90 (full=1, count=16).
4. FIFO full and a pop occurs in the same cycle as a write → pslverr=1. count decrements to 15.
5. Assert reset_n=0 after the 3rd bit of 0xFF with 2 bytes queued → data_out=0, tx_busy=0, mem_state=0 immediately. A read after release returns 0x40.
6. Under FIFO_TX_PARITY_EN, write 0x07 → 9 bits are output: 1,1,1,0,0,0,0,0 followed by parity 1.
